// File: rtl/taxi_pkg.sv
// ============================================================================
// Package : taxi_pkg
// Brief   : Widths, units and BCD helpers shared by the taxi fare datapath.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package taxi_pkg;

  localparam int FEE_W  = 14;
  localparam int BCD2_W = 8;
  localparam int FEE_UNIT = 1;  // one LSB of any fee value is 0.1 yuan
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [BCD2_W-1:0] BCD2_MAX = 8'h99;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [BCD2_W-1:0] bcd2_inc(input logic [BCD2_W-1:0] v);
    logic [BCD2_W-1:0] r;
    if (v == BCD2_MAX)
      r = v;
    else if (v[3:0] == BCD_DIGIT_MAX)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_cnt.sv
// ============================================================================
// Module : bcd2_cnt
// Brief  : Two-digit saturating BCD up-counter with clear, increment and hold.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2_cnt
  import taxi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [BCD2_W-1:0] q,
  output logic [BCD2_W-1:0] q_nxt,
  output logic              sat_o
);

  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = '0;
    else if (inc)
      q_nxt = bcd2_inc(q);
  end

  // Flags saturation of the value about to be loaded so callers can register it.
  assign sat_o = (q_nxt == BCD2_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/wait_fee_acc.sv
// ============================================================================
// Module : wait_fee_acc
// Brief  : Counts waiting minutes (BCD) and accrues the waiting surcharge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_fee_acc
  import taxi_pkg::*;
#(
  parameter int FREE_MIN      = 3,
  parameter int PRICE_PER_MIN = 10,
  parameter int FEE_MAX       = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              min_pulse,
  input  logic              max,
  output logic [BCD2_W-1:0] wait_min_bcd,
  output logic [FEE_W-1:0]  wait_fee,
  output logic              fee_tick,
  output logic              sat
);

  localparam logic [6:0]     FREE_INIT = 7'(FREE_MIN);
  localparam logic [FEE_W:0] PRICE_EXT = (FEE_W + 1)'(PRICE_PER_MIN);
  localparam logic [FEE_W:0] CAP_EXT   = (FEE_W + 1)'(FEE_MAX);

  logic             min_d;
  logic [6:0]       free_left;
  logic             tick;
  logic             qtick;
  logic             charge;
  logic [FEE_W:0]   fee_sum;
  logic [FEE_W-1:0] fee_nxt;
  logic [BCD2_W-1:0] min_nxt;
  logic             min_sat;

  // Both edges of the divider toggle mark a minute; clr and max drop the tick outright.
  assign tick   = min_pulse ^ min_d;
  assign qtick  = tick & en & ~max & ~clr;
  assign charge = qtick & (free_left == 7'd0);
  assign fee_sum = {1'b0, wait_fee} + PRICE_EXT;

  always_comb begin
    fee_nxt = wait_fee;
    if (clr)
      fee_nxt = '0;
    else if (charge)
      fee_nxt = (fee_sum > CAP_EXT) ? CAP_EXT[FEE_W-1:0] : fee_sum[FEE_W-1:0];
  end

  bcd2_cnt u_min_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (qtick),
    .q     (wait_min_bcd),
    .q_nxt (min_nxt),
    .sat_o (min_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_d     <= 1'b0;
      free_left <= FREE_INIT;
      wait_fee  <= '0;
      fee_tick  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      min_d    <= min_pulse;
      wait_fee <= fee_nxt;
      fee_tick <= charge & (fee_nxt != wait_fee);
      sat      <= min_sat | (fee_nxt == CAP_EXT[FEE_W-1:0]);
      if (clr)
        free_left <= FREE_INIT;
      else if (qtick && free_left != 7'd0)
        free_left <= free_left - 7'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wait_fee_acc.sv
// ============================================================================
// Module : tb_wait_fee_acc
// Brief  : Scoreboard bench for wait_fee_acc (default cap and a 50-unit cap).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_fee_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic min_pulse = 1'b0;
  logic max = 1'b0;

  logic [7:0]  wait_min_bcd, wait_min_bcd_c;
  logic [13:0] wait_fee, wait_fee_c;
  logic        fee_tick, fee_tick_c;
  logic        sat, sat_c;

  int total = 0;
  int bad = 0;
  int ticks_seen = 0;
  logic mon_on = 1'b0;

  typedef struct {
    logic [7:0]  mn;
    logic [13:0] fee;
    logic        tick;
    logic        sat;
    logic [13:0] fee_c;
    logic        tick_c;
    logic        sat_c;
  } exp_t;

  exp_t sb[$];

  int m_min, m_fee, m_fee_c, m_free;

  always #5 clk = ~clk;

  wait_fee_acc dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .min_pulse(min_pulse), .max(max),
    .wait_min_bcd(wait_min_bcd), .wait_fee(wait_fee), .fee_tick(fee_tick), .sat(sat)
  );

  wait_fee_acc #(.FREE_MIN(3), .PRICE_PER_MIN(10), .FEE_MAX(50)) dut_cap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .min_pulse(min_pulse), .max(max),
    .wait_min_bcd(wait_min_bcd_c), .wait_fee(wait_fee_c), .fee_tick(fee_tick_c), .sat(sat_c)
  );

  // Scoreboard: one entry per driven cycle, checked just after the following edge.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (fee_tick) ticks_seen++;
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (wait_min_bcd !== e.mn || wait_fee !== e.fee || fee_tick !== e.tick || sat !== e.sat) begin
          bad++;
          $display("FAIL sb_main: got min=%h fee=%0d tick=%b sat=%b, want min=%h fee=%0d tick=%b sat=%b",
                   wait_min_bcd, wait_fee, fee_tick, sat, e.mn, e.fee, e.tick, e.sat);
        end
        total++;
        if (wait_min_bcd_c !== e.mn || wait_fee_c !== e.fee_c || fee_tick_c !== e.tick_c || sat_c !== e.sat_c) begin
          bad++;
          $display("FAIL sb_cap: got min=%h fee=%0d tick=%b sat=%b, want min=%h fee=%0d tick=%b sat=%b",
                   wait_min_bcd_c, wait_fee_c, fee_tick_c, sat_c, e.mn, e.fee_c, e.tick_c, e.sat_c);
        end
      end else begin
        total++;
        if (fee_tick !== 1'b0 || fee_tick_c !== 1'b0) begin
          bad++;
          $display("FAIL idle_tick: got tick=%b tick_c=%b, want 0 0", fee_tick, fee_tick_c);
        end
      end
    end
  end

  task automatic model_reset();
    m_min = 0; m_fee = 0; m_fee_c = 0; m_free = 3;
  endtask

  task automatic drive_cycle(input logic tog, input logic do_clr);
    exp_t e;
    logic qual;
    int nf;
    @(negedge clk);
    if (tog) min_pulse = ~min_pulse;
    clr = do_clr;
    qual = tog && en && !max && !do_clr;
    e.tick = 1'b0;
    e.tick_c = 1'b0;
    if (do_clr) begin
      model_reset();
    end else if (qual) begin
      if (m_min < 99) m_min++;
      if (m_free > 0) begin
        m_free--;
      end else begin
        nf = (m_fee + 10 > 9999) ? 9999 : m_fee + 10;
        e.tick = (nf != m_fee);
        m_fee = nf;
        nf = (m_fee_c + 10 > 50) ? 50 : m_fee_c + 10;
        e.tick_c = (nf != m_fee_c);
        m_fee_c = nf;
      end
    end
    e.mn = {4'(m_min / 10), 4'(m_min % 10)};
    e.fee = 14'(m_fee);
    e.fee_c = 14'(m_fee_c);
    e.sat = (m_min == 99) || (m_fee == 9999);
    e.sat_c = (m_min == 99) || (m_fee_c == 50);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr = 1'b0;
    end
  endtask

  task automatic toggles(input int n);
    repeat (n) begin
      drive_cycle(1'b1, 1'b0);
      idle(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; min_pulse = 1'b0; en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (wait_min_bcd !== 8'h00 || wait_fee !== 14'd0 || fee_tick !== 1'b0 || sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: got min=%h fee=%0d tick=%b sat=%b, want 00 0 0 0",
               wait_min_bcd, wait_fee, fee_tick, sat);
    end
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if (fee_tick !== 1'b0 || wait_fee !== 14'd0 || wait_min_bcd !== 8'h00) begin
        bad++;
        $display("FAIL post_reset: got tick=%b fee=%0d min=%h, want 0 0 00", fee_tick, wait_fee, wait_min_bcd);
      end
    end
  endtask

  task automatic test_five();
    int t0;
    en = 1'b1;
    t0 = ticks_seen;
    toggles(5);
    idle(2);
    total++;
    if (wait_min_bcd !== 8'h05 || wait_fee !== 14'd20) begin
      bad++;
      $display("FAIL five_end: got min=%h fee=%0d, want 05 20", wait_min_bcd, wait_fee);
    end
    total++;
    if (ticks_seen - t0 !== 2) begin
      bad++;
      $display("FAIL five_ticks: got %0d pulses, want 2", ticks_seen - t0);
    end
  endtask

  task automatic test_twelve();
    drive_cycle(1'b0, 1'b1);
    idle(1);
    toggles(12);
    idle(1);
    total++;
    if (wait_min_bcd !== 8'h12 || wait_fee !== 14'd90) begin
      bad++;
      $display("FAIL twelve_end: got min=%h fee=%0d, want 12 90", wait_min_bcd, wait_fee);
    end
  endtask

  task automatic test_hundred();
    drive_cycle(1'b0, 1'b1);
    idle(1);
    toggles(105);
    idle(1);
    total++;
    if (wait_min_bcd !== 8'h99 || sat !== 1'b1 || wait_fee !== 14'd1020) begin
      bad++;
      $display("FAIL hundred_end: got min=%h sat=%b fee=%0d, want 99 1 1020", wait_min_bcd, sat, wait_fee);
    end
  endtask

  task automatic test_fee_cap();
    drive_cycle(1'b0, 1'b1);
    idle(1);
    toggles(10);
    idle(1);
    total++;
    if (wait_fee_c !== 14'd50 || sat_c !== 1'b1 || wait_min_bcd_c !== 8'h10) begin
      bad++;
      $display("FAIL cap_end: got fee=%0d sat=%b min=%h, want 50 1 10", wait_fee_c, sat_c, wait_min_bcd_c);
    end
  endtask

  task automatic test_hold();
    drive_cycle(1'b0, 1'b1);
    idle(1);
    toggles(4);
    max = 1'b1;
    toggles(3);
    max = 1'b0;
    en = 1'b0;
    toggles(3);
    idle(3);
    total++;
    if (wait_min_bcd !== 8'h04 || wait_fee !== 14'd10) begin
      bad++;
      $display("FAIL hold_end: got min=%h fee=%0d, want 04 10", wait_min_bcd, wait_fee);
    end
    en = 1'b1;
    toggles(1);
    total++;
    if (wait_min_bcd !== 8'h05 || wait_fee !== 14'd20) begin
      bad++;
      $display("FAIL hold_resume: got min=%h fee=%0d, want 05 20", wait_min_bcd, wait_fee);
    end
  endtask

  task automatic test_clr_toggle();
    drive_cycle(1'b1, 1'b1);
    idle(1);
    total++;
    if (wait_min_bcd !== 8'h00 || wait_fee !== 14'd0 || sat !== 1'b0) begin
      bad++;
      $display("FAIL clr_coinc: got min=%h fee=%0d sat=%b, want 00 0 0", wait_min_bcd, wait_fee, sat);
    end
    // Three free minutes must be available again after clr.
    toggles(4);
    total++;
    if (wait_min_bcd !== 8'h04 || wait_fee !== 14'd10) begin
      bad++;
      $display("FAIL clr_free: got min=%h fee=%0d, want 04 10", wait_min_bcd, wait_fee);
    end
  endtask

  task automatic test_async_rst();
    toggles(2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    min_pulse = 1'b0;
    #1;
    total++;
    if (wait_min_bcd !== 8'h00 || wait_fee !== 14'd0 || fee_tick !== 1'b0 || sat !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got min=%h fee=%0d tick=%b sat=%b, want 00 0 0 0",
               wait_min_bcd, wait_fee, fee_tick, sat);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    toggles(4);
    idle(1);
    total++;
    if (wait_min_bcd !== 8'h04 || wait_fee !== 14'd10) begin
      bad++;
      $display("FAIL after_rst: got min=%h fee=%0d, want 04 10", wait_min_bcd, wait_fee);
    end
  endtask

  initial begin
    test_reset();
    test_five();
    test_twelve();
    test_hundred();
    test_fee_cap();
    test_hold();
    test_clr_toggle();
    test_async_rst();
    idle(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
